// File: rtl/mem_req_pkg.sv
// Shared types for the two-port busy-handshake memory requester.
package mem_req_pkg;

    localparam int WORD_SIZE = 16;
    localparam logic [WORD_SIZE-1:0] ERR_WORD = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } port_state_e;

    typedef struct packed {
        logic                 we;
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic                 ready;
        logic                 err;
        logic [WORD_SIZE-1:0] rdata;
    } mem_rsp_t;

endpackage

// File: rtl/mem_port_fsm.sv
// One memory port: IDLE/ISSUE/BUSY/RESP sequencer with request latch and response register.
// Optional busy timeout is compiled in with MEM_TIMEOUT_EN.
module mem_port_fsm
    import mem_req_pkg::*;
#(
    parameter bit CAN_WRITE      = 1'b0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  mem_req_t             req,
    input  logic                 busy,
    input  logic [WORD_SIZE-1:0] rdata_in,
    output port_state_e          state,
    output mem_req_t             req_q,
    output mem_rsp_t             rsp
);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt;
`else
    localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            req_q <= '0;
            rsp   <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            rsp.ready <= 1'b0;
            rsp.err   <= 1'b0;
            case (state)
                // Waiting for busy to clear also swallows a read retrigger from the last access.
                IDLE: if (req_valid && !busy) begin
                    req_q.we    <= CAN_WRITE && req.we;
                    req_q.addr  <= req.addr;
                    req_q.wdata <= CAN_WRITE ? req.wdata : '0;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    state <= BUSY;
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                BUSY: begin
                    if (!busy) begin
                        rsp.rdata <= rdata_in;
                        rsp.ready <= 1'b1;
                        state     <= RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_cnt == CNT_LAST) begin
                        rsp.rdata <= ERR_WORD;
                        rsp.err   <= 1'b1;
                        rsp.ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_requester.sv
// CPU-side initiator for the two-port busy-handshake memory: I-port fetch, D-port load/store.
// Build with MEM_TIMEOUT_EN to add the per-port busy timeout and error response.
module mem_requester
    import mem_req_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    output logic                 i_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 d_err,
    output logic                 readM1,
    output logic [WORD_SIZE-1:0] address1,
    input  logic [WORD_SIZE-1:0] data1,
    input  logic                 M1busy,
    output logic                 readM2,
    output logic                 writeM2,
    output logic [WORD_SIZE-1:0] address2,
    inout  wire  [WORD_SIZE-1:0] data2,
    input  logic                 M2busy
);

    mem_req_t    i_req_s, d_req_s, i_q, d_q;
    mem_rsp_t    i_rsp, d_rsp;
    port_state_e i_state, d_state;
    logic        d_active;
    logic        unused_i_q;

    assign i_req_s = '{we: 1'b0, addr: i_addr, wdata: '0};
    assign d_req_s = '{we: d_we, addr: d_addr, wdata: d_wdata};

    mem_port_fsm #(.CAN_WRITE(1'b0), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_iport (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(i_req),
        .req      (i_req_s),
        .busy     (M1busy),
        .rdata_in (data1),
        .state    (i_state),
        .req_q    (i_q),
        .rsp      (i_rsp)
    );

    mem_port_fsm #(.CAN_WRITE(1'b1), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_dport (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(d_req),
        .req      (d_req_s),
        .busy     (M2busy),
        .rdata_in (data2),
        .state    (d_state),
        .req_q    (d_q),
        .rsp      (d_rsp)
    );

    assign unused_i_q = ^{i_q.we, i_q.wdata};
    assign d_active   = (d_state == ISSUE) || (d_state == BUSY);

    assign readM1   = (i_state == ISSUE);
    assign address1 = i_q.addr;

    // Read strobe stays up through capture so memory keeps driving data2;
    // write strobe drops with busy so the store commits only once.
    assign readM2   = !d_q.we && d_active;
    assign writeM2  = d_q.we && ((d_state == ISSUE) || ((d_state == BUSY) && M2busy));
    assign address2 = d_q.addr;
    assign data2    = (d_q.we && d_active) ? d_q.wdata : 'z;

    assign i_rdata = i_rsp.rdata;
    assign i_ready = i_rsp.ready;
    assign i_err   = i_rsp.err;
    assign d_rdata = d_rsp.rdata;
    assign d_ready = d_rsp.ready;
    assign d_err   = d_rsp.err;

endmodule
